// File: rtl/draw_sprite.sv
// Sprite overlay stage: latches position/mode/colour at each vblnk rise, computes the pixel ROM address,
// and delays timing plus background by ROM_LAT+2 cycles so the ROM data lines up with its pixel.
module draw_sprite #(
   parameter int          SPR_W     = 64,
   parameter int          SPR_H     = 64,
   parameter int          ADDR_W    = 12,
   parameter int          ROM_LAT   = 1,
   parameter logic [11:0] KEY_COLOR = 12'hFFF
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic [10:0]       hcount_in,
   input  logic [10:0]       vcount_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              hblnk_in,
   input  logic              vblnk_in,
   input  logic [11:0]       rgb_in,
   input  logic [11:0]       xpos,
   input  logic [11:0]       ypos,
   input  logic [1:0]        mode,
   input  logic [11:0]       fill_color,
   input  logic [11:0]       rgb_pixel,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic [10:0]       hcount_out,
   output logic [10:0]       vcount_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              hblnk_out,
   output logic              vblnk_out,
   output logic [11:0]       rgb_out,
   output logic              frame_tick
);

   localparam int D = ROM_LAT + 1;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
      logic        hit;
      logic [1:0]  mode;
      logic [11:0] fill;
   } pix_t;

   logic [11:0]       x_q, y_q, fill_q;
   logic [1:0]        mode_q;
   logic              vblnk_prev_q;
   pix_t              pipe_q [D];

   logic              latch_d;
   logic              hit_d;
   logic [12:0]       h13, v13, x13, y13, dx, dy;
   logic [ADDR_W-1:0] addr_d;
   pix_t              stage_d;
   pix_t              tail;
   logic [11:0]       rgb_d;

   // 13-bit compares keep X+SPR_W from wrapping, so sprites past the counter range are clipped
   always_comb begin
      h13     = {2'b00, hcount_in};
      v13     = {2'b00, vcount_in};
      x13     = {1'b0, x_q};
      y13     = {1'b0, y_q};
      hit_d   = (h13 >= x13) && (h13 < x13 + 13'(SPR_W)) &&
                (v13 >= y13) && (v13 < y13 + 13'(SPR_H));
      dx      = h13 - x13;
      dy      = v13 - y13;
      addr_d  = hit_d ? (ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx)) : '0;
      latch_d = vblnk_in & ~vblnk_prev_q;

      stage_d.hcount = hcount_in;
      stage_d.vcount = vcount_in;
      stage_d.hsync  = hsync_in;
      stage_d.vsync  = vsync_in;
      stage_d.hblnk  = hblnk_in;
      stage_d.vblnk  = vblnk_in;
      stage_d.rgb    = rgb_in;
      stage_d.hit    = hit_d;
      stage_d.mode   = mode_q;
      stage_d.fill   = fill_q;
   end

   // Mode and fill travel with the pixel so a shadow update never splits a visible span
   always_comb begin
      tail  = pipe_q[D-1];
      rgb_d = tail.rgb;
      if (!(tail.hblnk || tail.vblnk) && tail.hit) begin
         case (tail.mode)
            2'b01:   rgb_d = tail.fill;
            2'b10:   rgb_d = (rgb_pixel == KEY_COLOR) ? tail.rgb : rgb_pixel;
            2'b11:   rgb_d = rgb_pixel;
            default: rgb_d = tail.rgb;
         endcase
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         fill_q       <= '0;
         mode_q       <= '0;
         vblnk_prev_q <= 1'b0;
         frame_tick   <= 1'b0;
         pixel_addr   <= '0;
         for (int i = 0; i < D; i++) pipe_q[i] <= '0;
         hcount_out   <= '0;
         vcount_out   <= '0;
         hsync_out    <= 1'b0;
         vsync_out    <= 1'b0;
         hblnk_out    <= 1'b0;
         vblnk_out    <= 1'b0;
         rgb_out      <= '0;
      end else begin
         vblnk_prev_q <= vblnk_in;
         frame_tick   <= latch_d;
         if (latch_d) begin
            x_q    <= xpos;
            y_q    <= ypos;
            mode_q <= mode;
            fill_q <= fill_color;
         end
         pixel_addr <= addr_d;
         pipe_q[0]  <= stage_d;
         for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
         hcount_out <= tail.hcount;
         vcount_out <= tail.vcount;
         hsync_out  <= tail.hsync;
         vsync_out  <= tail.vsync;
         hblnk_out  <= tail.hblnk;
         vblnk_out  <= tail.vblnk;
         rgb_out    <= rgb_d;
      end
   end

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite at ROM_LAT=1 and ROM_LAT=3 sharing one stimulus stream,
// checked every cycle against a per-pixel model plus hand-computed literal pixels.
module tb_draw_sprite;
   localparam int N = 2048;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic        rst;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in, xpos, ypos, fill_color;
   logic [1:0]  mode;

   logic [11:0] pa_a, pa_b, rp_a, rp_b, rgb_a, rgb_b;
   logic [10:0] ho_a, vo_a, ho_b, vo_b;
   logic        hs_a, vs_a, hb_a, vb_a, ft_a, hs_b, vs_b, hb_b, vb_b, ft_b;

   draw_sprite #(.ROM_LAT(1)) u_a (
      .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .mode(mode), .fill_color(fill_color),
      .rgb_pixel(rp_a), .pixel_addr(pa_a), .hcount_out(ho_a), .vcount_out(vo_a),
      .hsync_out(hs_a), .vsync_out(vs_a), .hblnk_out(hb_a), .vblnk_out(vb_a),
      .rgb_out(rgb_a), .frame_tick(ft_a));

   draw_sprite #(.ROM_LAT(3)) u_b (
      .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .mode(mode), .fill_color(fill_color),
      .rgb_pixel(rp_b), .pixel_addr(pa_b), .hcount_out(ho_b), .vcount_out(vo_b),
      .hsync_out(hs_b), .vsync_out(vs_b), .hblnk_out(hb_b), .vblnk_out(vb_b),
      .rgb_out(rgb_b), .frame_tick(ft_b));

   function automatic logic [11:0] rom_f(input logic [11:0] a);
      int t;
      if (a == 12'd0) return 12'hFFF;
      if (a == 12'd1) return 12'h123;
      t = int'(a) * 37 + 5;
      return t[11:0];
   endfunction

   // ROM models: data appears ROM_LAT cycles after the address
   logic [11:0] rom_a;
   logic [11:0] rom_b [3];
   always @(posedge pclk) begin
      rom_a    <= rom_f(pa_a);
      rom_b[0] <= rom_f(pa_b);
      rom_b[1] <= rom_b[0];
      rom_b[2] <= rom_b[1];
   end
   assign rp_a = rom_a;
   assign rp_b = rom_b[2];

   // Per-cycle record of inputs and model results
   bit          rst_h [N];
   logic [10:0] h_h [N], v_h [N];
   logic        hs_h [N], vs_h [N], hb_h [N], vb_h [N], latch_h [N];
   logic [11:0] rgb_h [N], addr_h [N], exp_rgb [N];
   logic [11:0] ix_h [N], iy_h [N], if_h [N];
   logic [1:0]  im_h [N];
   bit          lit_rv [N], lit_av [N];
   logic [11:0] lit_r [N], lit_a [N];

   int sx, sy, sm, sf;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   bit running = 1'b0;

   logic        st_rst;
   logic [11:0] st_x, st_y, st_fill;
   logic [1:0]  st_mode;

   function automatic bit rst_at(input int j);
      if (j < 0) return 1'b1;
      return rst_h[j];
   endfunction

   task automatic record(input int k);
      bit          hit, prev_vb;
      logic [11:0] a, rd;
      if (k == 0 || rst_h[k-1]) begin
         sx = 0; sy = 0; sm = 0; sf = 0;
      end else if (latch_h[k-1]) begin
         sx = int'(ix_h[k-1]); sy = int'(iy_h[k-1]);
         sm = int'(im_h[k-1]); sf = int'(if_h[k-1]);
      end
      if (rst_h[k]) begin
         sx = 0; sy = 0; sm = 0; sf = 0;
      end
      prev_vb    = (k == 0 || rst_h[k-1]) ? 1'b0 : vb_h[k-1];
      latch_h[k] = vb_h[k] && !prev_vb;
      hit = int'(h_h[k]) >= sx && int'(h_h[k]) < sx + 64 &&
            int'(v_h[k]) >= sy && int'(v_h[k]) < sy + 64;
      a  = hit ? 12'(((int'(v_h[k]) - sy) * 64 + (int'(h_h[k]) - sx)) & 32'hFFF) : 12'd0;
      rd = rom_f(a);
      addr_h[k] = a;
      if (hb_h[k] || vb_h[k] || !hit || sm == 0) exp_rgb[k] = rgb_h[k];
      else if (sm == 1)                          exp_rgb[k] = 12'(sf);
      else if (sm == 2)                          exp_rgb[k] = (rd == 12'hFFF) ? rgb_h[k] : rd;
      else                                       exp_rgb[k] = rd;
   endtask

   task automatic apply(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb);
      rst = st_rst; hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb;
      hsync_in = h[3]; vsync_in = v[2]; rgb_in = {v[3:0], h[7:0]};
      xpos = st_x; ypos = st_y; mode = st_mode; fill_color = st_fill;
      rst_h[cyc] = st_rst; h_h[cyc] = h; v_h[cyc] = v; hb_h[cyc] = hb; vb_h[cyc] = vb;
      hs_h[cyc] = h[3]; vs_h[cyc] = v[2]; rgb_h[cyc] = {v[3:0], h[7:0]};
      ix_h[cyc] = st_x; iy_h[cyc] = st_y; im_h[cyc] = st_mode; if_h[cyc] = st_fill;
      record(cyc);
   endtask

   task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb);
      @(posedge pclk);
      #1;
      cyc = cyc + 1;
      apply(h, v, hb, vb);
   endtask

   task automatic drive_l(input logic [10:0] h, input logic [10:0] v, input logic [11:0] r);
      drive(h, v, 1'b0, 1'b0);
      lit_rv[cyc] = 1'b1;
      lit_r[cyc]  = r;
   endtask

   task automatic drive_a(input logic [10:0] h, input logic [10:0] v, input logic [11:0] a,
                          input logic [11:0] r);
      drive_l(h, v, r);
      lit_av[cyc] = 1'b1;
      lit_a[cyc]  = a;
   endtask

   task automatic row(input logic [10:0] v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) drive(11'(h), v, 1'b0, 1'b0);
   endtask

   task automatic latch_frame();
      drive(11'd5, 11'd479, 1'b0, 1'b0);
      drive(11'd0, 11'd480, 1'b1, 1'b1);
      drive(11'd0, 11'd481, 1'b1, 1'b1);
      drive(11'd0, 11'd482, 1'b1, 1'b1);
      drive(11'd0, 11'd0, 1'b1, 1'b0);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic cmp_dut(input string nm, input int lat, input logic [10:0] ho, input logic [10:0] vo,
                          input logic hs, input logic vs, input logic hb, input logic vb,
                          input logic [11:0] rgb, input logic [11:0] pa, input logic ft);
      int m, k;
      bit z, z1;
      logic [25:0] exp_t;
      m  = cyc;
      k  = m - (lat + 2);
      z  = 1'b0;
      for (int j = k; j <= m; j++) if (rst_at(j)) z = 1'b1;
      z1 = rst_at(m) || rst_at(m - 1);
      exp_t = z ? 26'd0 : {h_h[k], v_h[k], hs_h[k], vs_h[k], hb_h[k], vb_h[k]};
      check({nm, "_timing"}, 32'({ho, vo, hs, vs, hb, vb}), 32'(exp_t));
      check({nm, "_rgb"}, 32'(rgb), z ? 32'd0 : 32'(exp_rgb[k]));
      check({nm, "_addr"}, 32'(pa), z1 ? 32'd0 : 32'(addr_h[m-1]));
      check({nm, "_tick"}, 32'(ft), z1 ? 32'd0 : 32'(latch_h[m-1]));
      if (k >= 0 && lit_rv[k]) check({nm, "_lit_rgb"}, 32'(rgb), 32'(lit_r[k]));
      if (m >= 1 && lit_av[m-1]) check({nm, "_lit_addr"}, 32'(pa), 32'(lit_a[m-1]));
   endtask

   always @(negedge pclk) begin
      if (running) begin
         cmp_dut("lat1", 1, ho_a, vo_a, hs_a, vs_a, hb_a, vb_a, rgb_a, pa_a, ft_a);
         cmp_dut("lat3", 3, ho_b, vo_b, hs_b, vs_b, hb_b, vb_b, rgb_b, pa_b, ft_b);
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         lit_rv[i] = 1'b0;
         lit_av[i] = 1'b0;
      end
      st_rst = 1'b1; st_x = 12'd0; st_y = 12'd0; st_mode = 2'b01; st_fill = 12'hABC;
      apply(11'd0, 11'd0, 1'b1, 1'b1);
      running = 1'b1;

      // reset, then pass-through while the shadow mode is still off
      drive(11'd1, 11'd3, 1'b0, 1'b0);
      drive(11'd2, 11'd3, 1'b0, 1'b0);
      st_rst = 1'b0;
      row(11'd3, 3, 4);
      drive_l(11'd5, 11'd3, 12'h305);
      row(11'd3, 6, 15);
      st_rst = 1'b1;
      row(11'd3, 16, 17);
      st_rst = 1'b0;
      row(11'd3, 18, 30);

      // solid fill at (100,50)
      st_mode = 2'b01; st_fill = 12'h0F0; st_x = 12'd100; st_y = 12'd50;
      latch_frame();
      row(11'd50, 97, 98);
      drive_l(11'd99, 11'd50, 12'h263);
      drive_l(11'd100, 11'd50, 12'h0F0);
      row(11'd50, 101, 102);
      row(11'd50, 160, 163);
      drive_l(11'd164, 11'd50, 12'h2A4);
      row(11'd50, 165, 166);
      drive(11'd120, 11'd60, 1'b1, 1'b0);
      row(11'd60, 119, 121);
      drive_l(11'd163, 11'd113, 12'h0F0);
      row(11'd113, 164, 165);
      drive_l(11'd100, 11'd114, 12'h264);
      row(11'd49, 100, 101);

      // opaque image: address and ROM data
      st_mode = 2'b11; st_x = 12'd10; st_y = 12'd20;
      latch_frame();
      row(11'd22, 8, 14);
      drive_a(11'd15, 11'd22, 12'd133, 12'h33E);
      row(11'd22, 16, 20);

      // keyed image
      st_mode = 2'b10;
      latch_frame();
      row(11'd20, 8, 9);
      drive_a(11'd10, 11'd20, 12'd0, 12'h40A);
      drive_a(11'd11, 11'd20, 12'd1, 12'h123);
      row(11'd20, 12, 14);

      // shadowing: mid-frame xpos change waits for the next vblnk rise
      st_mode = 2'b01; st_fill = 12'h0F0; st_x = 12'd100; st_y = 12'd150;
      latch_frame();
      row(11'd199, 98, 102);
      st_x = 12'd300;
      row(11'd200, 98, 99);
      drive_l(11'd100, 11'd200, 12'h0F0);
      row(11'd200, 101, 102);
      row(11'd200, 298, 299);
      drive_l(11'd300, 11'd200, 12'h82C);
      row(11'd200, 301, 302);
      latch_frame();
      row(11'd200, 98, 99);
      drive_l(11'd100, 11'd200, 12'h864);
      row(11'd200, 298, 299);
      drive_l(11'd300, 11'd200, 12'h0F0);

      // right-edge clipping, no wrap to h=0
      st_x = 12'd2040; st_y = 12'd0;
      latch_frame();
      row(11'd5, 2036, 2038);
      drive_l(11'd2039, 11'd5, 12'h5F7);
      row(11'd5, 2040, 2046);
      drive_l(11'd2047, 11'd5, 12'h0F0);
      drive_l(11'd0, 11'd5, 12'h500);
      row(11'd5, 1, 3);

      for (int i = 0; i < 8; i++) drive(11'd0, 11'd0, 1'b1, 1'b0);
      @(negedge pclk);
      running = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
